// File: rtl/bht_pkg.sv
// Shared types for the branch history table port arbiter: counter type,
// grant encoding, reset counter value and the queued update entry.
package bht_pkg;

  typedef logic [1:0] cnt_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_LOOK = 2'd1,
    G_UPD  = 2'd2
  } grant_t;

  // Weakly not taken.
  localparam cnt_t CNT_INIT = 2'b01;

  // Widest table index an update entry can carry; the top zero-extends.
  localparam int MAX_INDEX_W = 16;

  typedef struct packed {
    logic [MAX_INDEX_W-1:0] index;
    logic                   taken;
  } upd_entry_t;

  // Two-bit saturating counter step.
  function automatic cnt_t cnt_next(input cnt_t c, input logic taken);
    cnt_t n;
    unique case (c)
      2'b00:   n = taken ? 2'b01 : 2'b00;
      2'b01:   n = taken ? 2'b10 : 2'b00;
      2'b10:   n = taken ? 2'b11 : 2'b01;
      default: n = taken ? 2'b11 : 2'b10;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Synchronous update queue for the BHT arbiter with full/empty flags.
// Push and pop in the same cycle are allowed; push is ignored when full.
module bht_upd_fifo
  import bht_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  upd_entry_t i_entry,
  input  logic       i_pop,
  output upd_entry_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  upd_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // Entry storage write.
  // NOTE: the storage array has no reset; occupancy is tracked by r_count, so stale entries are never read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/bht_port_arbiter.sv
// Branch history table of 2-bit counters with a single access port shared
// by fetch lookups and queued resolved-branch updates. Lookups win unless
// the queue is full or updates have been starved for STARVE_MAX grants.
// Optional feature: define BHT_UPD_BYPASS_EN to write an update straight
// into the table when the queue is empty and the port is otherwise idle.
module bht_port_arbiter
  import bht_pkg::*;
#(
  parameter int INDEX_W    = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lookup_vld,
  input  logic [31:0] i_lookup_pc,
  output logic        o_lookup_rdy,
  output logic        o_pred_vld,
  output logic        o_pred_taken,
  output logic [1:0]  o_pred_state,
  input  logic        i_upd_vld,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  output logic        o_upd_rdy,
  output logic        o_busy
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int SW      = $clog2(STARVE_MAX + 1);

  cnt_t              r_table [ENTRIES];
  logic [SW-1:0]     r_starve;
  logic              r_pred_vld;
  cnt_t              r_pred_state;

  logic [INDEX_W-1:0] w_look_idx;
  logic [INDEX_W-1:0] w_upd_idx;
  logic [INDEX_W-1:0] w_head_idx;
  logic               w_full;
  logic               w_empty;
  logic               w_force;
  logic               w_push_ok;
  logic               w_bypass;
  logic               w_fifo_push;
  logic               w_wr_en;
  logic [INDEX_W-1:0] w_wr_idx;
  logic               w_wr_taken;
  grant_t             w_grant;
  upd_entry_t         w_push_entry;
  upd_entry_t         w_head;

  assign w_look_idx = i_lookup_pc[INDEX_W+1:2];
  assign w_upd_idx  = i_upd_pc[INDEX_W+1:2];
  assign w_head_idx = w_head.index[INDEX_W-1:0];

  assign w_force      = w_full | (r_starve == SW'(STARVE_MAX));
  assign o_lookup_rdy = ~w_force;
  assign o_upd_rdy    = ~w_full;
  assign o_busy       = ~w_empty;
  assign o_pred_vld   = r_pred_vld;
  assign o_pred_state = r_pred_state;
  assign o_pred_taken = r_pred_state[1];
  assign w_push_ok    = i_upd_vld & ~w_full;

  assign w_push_entry.index = MAX_INDEX_W'(w_upd_idx);
  assign w_push_entry.taken = i_upd_taken;

  // Port grant: lookup first, then queued update, else idle.
  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    w_grant = G_NONE;
    if (i_lookup_vld && !w_force) w_grant = G_LOOK;
    else if (!w_empty)            w_grant = G_UPD;
  end

`ifdef BHT_UPD_BYPASS_EN
  assign w_bypass = w_push_ok & w_empty & (w_grant == G_NONE);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_fifo_push = w_push_ok & ~w_bypass;

  // Single table write port: queue head on G_UPD, or the bypassed update.
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_idx   = w_head_idx;
    w_wr_taken = w_head.taken;
    if (w_grant == G_UPD) begin
      w_wr_en = 1'b1;
    end else if (w_bypass) begin
      w_wr_en    = 1'b1;
      w_wr_idx   = w_upd_idx;
      w_wr_taken = i_upd_taken;
    end
  end

  bht_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_fifo_push),
    .i_entry (w_push_entry),
    .i_pop   (w_grant == G_UPD),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Counter table; every entry must start weakly not taken, so it is reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= CNT_INIT;
    end else if (w_wr_en) begin
      r_table[w_wr_idx] <= cnt_next(r_table[w_wr_idx], w_wr_taken);
    end
  end

  // Starvation counter and registered prediction path.
  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve     <= '0;
      r_pred_vld   <= 1'b0;
      r_pred_state <= CNT_INIT;
    end else begin
      r_pred_vld <= (w_grant == G_LOOK);
      if (w_grant == G_LOOK) r_pred_state <= r_table[w_look_idx];

      if (w_grant == G_UPD || w_empty)
        r_starve <= '0;
      else if (w_grant == G_LOOK && r_starve != SW'(STARVE_MAX))
        r_starve <= r_starve + 1'b1;
    end
  end

endmodule

// File: tb/tb_bht_port_arbiter.sv
// Directed self-checking bench for bht_port_arbiter (default parameters).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_bht_port_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_lookup_vld;
  logic [31:0] i_lookup_pc;
  logic        o_lookup_rdy;
  logic        o_pred_vld;
  logic        o_pred_taken;
  logic [1:0]  o_pred_state;
  logic        i_upd_vld;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic        o_upd_rdy;
  logic        o_busy;

  int n_tests;
  int n_fail;

  bht_port_arbiter dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_lookup_vld (i_lookup_vld),
    .i_lookup_pc  (i_lookup_pc),
    .o_lookup_rdy (o_lookup_rdy),
    .o_pred_vld   (o_pred_vld),
    .o_pred_taken (o_pred_taken),
    .o_pred_state (o_pred_state),
    .i_upd_vld    (i_upd_vld),
    .i_upd_pc     (i_upd_pc),
    .i_upd_taken  (i_upd_taken),
    .o_upd_rdy    (o_upd_rdy),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_lookup_vld = 1'b0;
    i_upd_vld    = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // One-cycle lookup, then check the prediction on the following cycle.
  task automatic lookup_check(input string tag, input logic [31:0] pc, input logic [1:0] exp_state);
    i_upd_vld    = 1'b0;
    i_lookup_vld = 1'b1;
    i_lookup_pc  = pc;
    tick();
    i_lookup_vld = 1'b0;
    check({tag, "_vld"},   {31'd0, o_pred_vld},   32'd1);
    check({tag, "_state"}, {30'd0, o_pred_state}, {30'd0, exp_state});
    check({tag, "_taken"}, {31'd0, o_pred_taken}, {31'd0, exp_state[1]});
  endtask

  task automatic update(input logic [31:0] pc, input logic taken);
    i_lookup_vld = 1'b0;
    i_upd_vld    = 1'b1;
    i_upd_pc     = pc;
    i_upd_taken  = taken;
    tick();
    i_upd_vld    = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    i_rst        = 1'b1;
    i_lookup_vld = 1'b0;
    i_lookup_pc  = '0;
    i_upd_vld    = 1'b0;
    i_upd_pc     = '0;
    i_upd_taken  = 1'b0;

    // Reset values, during and after reset.
    repeat (2) tick();
    check("rst_pred_vld",   {31'd0, o_pred_vld},   32'd0);
    check("rst_pred_taken", {31'd0, o_pred_taken}, 32'd0);
    check("rst_pred_state", {30'd0, o_pred_state}, 32'd1);
    check("rst_busy",       {31'd0, o_busy},       32'd0);
    check("rst_upd_rdy",    {31'd0, o_upd_rdy},    32'd1);
    check("rst_look_rdy",   {31'd0, o_lookup_rdy}, 32'd1);
    i_rst = 1'b0;
    tick();
    check("post_rst_busy", {31'd0, o_busy}, 32'd0);

    // First lookup after reset: weakly not taken, one-cycle pulse.
    lookup_check("look40_init", 32'h40, 2'b01);
    tick();
    check("pred_pulse_end", {31'd0, o_pred_vld}, 32'd0);

    // Three taken updates with no lookups: 01->10->11->11.
    update(32'h40, 1'b1);
`ifndef BHT_UPD_BYPASS_EN
    check("upd_queued_busy", {31'd0, o_busy}, 32'd1);
`endif
    update(32'h40, 1'b1);
    update(32'h40, 1'b1);
    idle(3);
    check("upd_drained_busy", {31'd0, o_busy}, 32'd0);
    lookup_check("look40_sat", 32'h40, 2'b11);

    // Not-taken step down from 11, and saturation at 00.
    update(32'h40, 1'b0);
    idle(3);
    lookup_check("look40_dn", 32'h40, 2'b10);
    update(32'h44, 1'b0);
    idle(2);
    update(32'h44, 1'b0);
    idle(3);
    lookup_check("look44_zero", 32'h44, 2'b00);
    idle(1);

    // Starvation: one update queued under continuous lookups.
    i_lookup_vld = 1'b1;
    i_lookup_pc  = 32'h0;
    i_upd_vld    = 1'b1;
    i_upd_pc     = 32'h48;
    i_upd_taken  = 1'b1;
    tick();
    i_upd_vld = 1'b0;
    check("starve_busy",  {31'd0, o_busy},       32'd1);
    check("starve_rdy_a", {31'd0, o_lookup_rdy}, 32'd1);
    tick();
    tick();
    check("starve_rdy_c", {31'd0, o_lookup_rdy}, 32'd1);
    tick();
    check("starve_force",   {31'd0, o_lookup_rdy}, 32'd0);
    check("starve_pred_on", {31'd0, o_pred_vld},   32'd1);
    tick();
    check("starve_popped",   {31'd0, o_busy},       32'd0);
    check("starve_rdy_back", {31'd0, o_lookup_rdy}, 32'd1);
    check("starve_no_pred",  {31'd0, o_pred_vld},   32'd0);
    idle(1);
    lookup_check("look48", 32'h48, 2'b10);
    idle(1);

    // Fill the queue while lookups hold the port.
    i_lookup_vld = 1'b1;
    i_lookup_pc  = 32'h0;
    i_upd_vld    = 1'b1;
    i_upd_pc     = 32'h4c;
    i_upd_taken  = 1'b1;
    tick();
    check("fill_rdy_1", {31'd0, o_upd_rdy}, 32'd1);
    tick();
    tick();
    tick();
    i_upd_vld = 1'b0;
    check("full_upd_rdy",  {31'd0, o_upd_rdy},    32'd0);
    check("full_look_rdy", {31'd0, o_lookup_rdy}, 32'd0);
    check("full_busy",     {31'd0, o_busy},       32'd1);
    tick();
    check("pop_upd_rdy",  {31'd0, o_upd_rdy},    32'd1);
    check("pop_look_rdy", {31'd0, o_lookup_rdy}, 32'd1);
    idle(6);
    check("fill_drained", {31'd0, o_busy}, 32'd0);
    lookup_check("look4c", 32'h4c, 2'b11);
    idle(1);

    // Reset mid-operation with two queued updates.
    i_lookup_vld = 1'b1;
    i_lookup_pc  = 32'h0;
    i_upd_vld    = 1'b1;
    i_upd_pc     = 32'h50;
    i_upd_taken  = 1'b1;
    tick();
    tick();
    i_upd_vld = 1'b0;
    check("pre_rst_busy",     {31'd0, o_busy},     32'd1);
    check("pre_rst_pred_vld", {31'd0, o_pred_vld}, 32'd1);
    i_lookup_vld = 1'b0;
    i_rst = 1'b1;
    #1;
    check("mid_rst_busy",     {31'd0, o_busy},       32'd0);
    check("mid_rst_pred_vld", {31'd0, o_pred_vld},   32'd0);
    check("mid_rst_upd_rdy",  {31'd0, o_upd_rdy},    32'd1);
    check("mid_rst_look_rdy", {31'd0, o_lookup_rdy}, 32'd1);
    tick();
    i_rst = 1'b0;
    tick();
    lookup_check("look50_rst", 32'h50, 2'b01);
    lookup_check("look40_rst", 32'h40, 2'b01);
    idle(1);

    // Idle update followed by a lookup to the same entry.
    update(32'h80, 1'b1);
`ifdef BHT_UPD_BYPASS_EN
    check("byp_busy", {31'd0, o_busy}, 32'd0);
    lookup_check("look80_byp", 32'h80, 2'b10);
`else
    lookup_check("look80_stale", 32'h80, 2'b01);
`endif
    idle(3);
    lookup_check("look80_final", 32'h80, 2'b10);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bht_port_arbiter.md
BHT_PORT_ARBITER -- requirements
Module: bht_port_arbiter

Interface
REQ-001 SHALL have parameter INDEX_W, default 6, table index width (2^INDEX_W two-bit counters).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, update-queue entries (power of two, >=2).
REQ-003 SHALL have parameter STARVE_MAX, default 3, maximum consecutive lookup grants while updates are pending.
REQ-004 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_lookup_vld  input  1  fetch requests a prediction.
REQ-007 SHALL have port i_lookup_pc  input  32  fetch PC.
REQ-008 SHALL have port o_lookup_rdy  output  1  lookup accepted this cycle when high with i_lookup_vld.
REQ-009 SHALL have port o_pred_vld  output  1  prediction valid, one-cycle pulse.
REQ-010 SHALL have port o_pred_taken  output  1  predicted direction (1 = taken).
REQ-011 SHALL have port o_pred_state  output  2  counter value used for the prediction.
REQ-012 SHALL have port i_upd_vld  input  1  resolved branch update offered.
REQ-013 SHALL have port i_upd_pc  input  32  resolved branch PC.
REQ-014 SHALL have port i_upd_taken  input  1  actual outcome.
REQ-015 SHALL have port o_upd_rdy  output  1  update accepted when high with i_upd_vld.
REQ-016 SHALL have port o_busy  output  1  update queue non-empty.

Function
REQ-017 SHALL index the table with pc[INDEX_W+1:2] for both lookups and updates.
REQ-018 SHALL perform at most one table access per cycle; the grant is one of G_NONE, G_LOOK or G_UPD.
REQ-019 SHALL compute force = fifo_full OR starve_cnt == STARVE_MAX; o_lookup_rdy = NOT force.
REQ-020 SHALL decide the grant by priority: G_LOOK if i_lookup_vld AND NOT force; else G_UPD if the queue is non-empty; else G_NONE.
REQ-021 SHALL, on G_LOOK, register the counter value and assert o_pred_vld for exactly one cycle (latency 1), with o_pred_taken = counter[1].
REQ-022 SHALL, on G_UPD, pop the queue head and saturate-update its counter: 00->01/00, 01->10/00, 10->11/01, 11->11/10 (taken/not taken).
REQ-023 SHALL set o_upd_rdy = NOT fifo_full; push and pop in the same cycle are legal whenever the queue is not full.
REQ-024 SHALL increment starve_cnt, saturating at STARVE_MAX, on G_LOOK while the queue is non-empty, and clear it on G_UPD or when the queue is empty.
REQ-025 SHALL give a lookup to an index with a pending queued update the stale table value; no forwarding.
REQ-026 SHALL drive o_busy = queue non-empty; outputs other than the prediction path SHALL depend only on registered state.

Reset
REQ-027 SHALL, on i_rst, initialise every counter to 01 (weakly not taken), empty the queue, and clear starve_cnt.
REQ-028 SHALL hold o_pred_vld = 0, o_pred_taken = 0, o_pred_state = 01, o_busy = 0, o_upd_rdy = 1 and o_lookup_rdy = 1 during and after reset.
REQ-029 SHALL discard any queued, unapplied update and any in-flight prediction when reset is asserted mid-operation.

Configuration
REQ-030 SHALL, when BHT_UPD_BYPASS_EN is defined, apply an accepted update directly to the table in its acceptance cycle (no enqueue) if the queue is empty and the grant would otherwise be G_NONE.
REQ-031 SHALL, when BHT_UPD_BYPASS_EN is undefined, enqueue every accepted update, so the earliest table write is the cycle after acceptance.

Structure
REQ-032 SHALL take the following from package bht_pkg: counter typedef, grant enum (G_NONE/G_LOOK/G_UPD), constant CNT_INIT = 2'b01, and the update-entry struct (index, taken).
REQ-033 SHALL implement the update queue as sub-module bht_upd_fifo (synchronous FIFO with full/empty flags).

Verification
REQ-034 SHALL cover: reset then lookup pc=0x40 -> next cycle o_pred_vld=1, o_pred_taken=0, o_pred_state=01.
REQ-035 SHALL cover: three taken updates to pc=0x40 with no lookups, then lookup 0x40 -> o_pred_state=11, o_pred_taken=1.
REQ-036 SHALL cover: continuous lookups with one update queued -> update granted after exactly 3 lookup grants (o_lookup_rdy=0 for one cycle), after which o_busy=0.
REQ-037 SHALL cover: 4 updates pushed while lookups hold the port -> o_upd_rdy=0 with queue full, o_lookup_rdy=0 until a pop occurs.
REQ-038 SHALL cover: i_rst asserted with 2 queued updates -> o_busy=0 immediately, and a subsequent lookup returns state 01.
REQ-039 SHALL cover: with BHT_UPD_BYPASS_EN, an idle taken update to 0x80 followed next cycle by lookup 0x80 -> o_pred_state=10.
